// File: rtl/game_pkg.sv
// Shared round-state encoding for the round controller, display and scoring blocks.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAYING   = 3'd2,
    PAUSED    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Buttons, timer handshake and display outputs of the round controller, bundled.
interface game_round_ctrl_if;
  import game_pkg::*;

  logic               start_btn;
  logic               pause_btn;
  logic [7:0]         time_left;
  logic               timer_go;
  logic               timer_restart;
  logic [STATE_W-1:0] game_state;
  logic [3:0]         countdown_val;
  logic               input_enable;
  logic               game_over;

  // The controller drives the timer and display; the environment drives buttons and time_left.
  modport master (
    input  start_btn, pause_btn, time_left,
    output timer_go, timer_restart, game_state, countdown_val, input_enable, game_over
  );

  modport slave (
    output start_btn, pause_btn, time_left,
    input  timer_go, timer_restart, game_state, countdown_val, input_enable, game_over
  );

endinterface

// File: rtl/sec_ticker.sv
// Free-running one-second tick generator; clear restarts the second from zero.
module sec_ticker #(
  parameter logic [23:0] ONE_SEC = 24'd10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [23:0] count;

  assign tick = (count == ONE_SEC - 24'd1);

  always_ff @(posedge clock) begin
    if (reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: title, ready countdown, play, pause and game-over, driving the round timer.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter logic [3:0]  COUNTDOWN_SECS = 4'd3,
  parameter logic [23:0] ONE_SEC        = 24'd10000000,
  parameter logic [3:0]  OVER_HOLD_SECS = 4'd2
) (
  input logic              clock,
  input logic              reset,
  game_round_ctrl_if.master bus
);

  logic               start_q;
  logic               pause_q;
  logic               post_reset;
  logic               start_edge;
  logic               pause_edge;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_n;
  logic [3:0]         cd_val;
  logic [3:0]         cd_val_n;
  logic [3:0]         hold_cnt;
  logic [3:0]         hold_cnt_n;
  logic               hold_expired;

  logic               enter_countdown;
  logic               enter_game_over;
  logic               sec_clear;
  logic               sec_tick;

  logic               go_q;
  logic               restart_q;
  logic               input_en_q;
  logic               over_q;

  // post_reset masks edges in the first cycle after reset so a button held through reset stays quiet.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      post_reset <= 1'b1;
    end else begin
      start_q    <= bus.start_btn;
      pause_q    <= bus.pause_btn;
      post_reset <= 1'b0;
    end
  end

  assign start_edge = bus.start_btn & ~start_q & ~post_reset;
  assign pause_edge = bus.pause_btn & ~pause_q & ~post_reset;

  sec_ticker #(
    .ONE_SEC (ONE_SEC)
  ) u_sec_ticker (
    .clock (clock),
    .reset (reset),
    .clear (sec_clear),
    .tick  (sec_tick)
  );

  assign hold_expired = (hold_cnt >= OVER_HOLD_SECS);

  always_comb begin
    state_n    = state;
    cd_val_n   = cd_val;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_n  = COUNTDOWN;
          cd_val_n = COUNTDOWN_SECS;
        end
      end
      COUNTDOWN: begin
        if (sec_tick) begin
          if (cd_val <= 4'd1) begin
            state_n  = PLAYING;
            cd_val_n = 4'd0;
          end else begin
            cd_val_n = cd_val - 4'd1;
          end
        end
      end
      PLAYING: begin
        if (bus.time_left == 8'd0) begin
          state_n = GAME_OVER;
        end else if (pause_edge) begin
          state_n = PAUSED;
        end
      end
      PAUSED: begin
        // Pause beats start when both arrive together: the player resumes rather than quits.
        if (pause_edge) begin
          state_n = PLAYING;
        end else if (start_edge) begin
          state_n = IDLE;
        end
      end
      GAME_OVER: begin
        if (sec_tick && !hold_expired) begin
          hold_cnt_n = hold_cnt + 4'd1;
        end
        if (start_edge && hold_expired) begin
          state_n  = COUNTDOWN;
          cd_val_n = COUNTDOWN_SECS;
        end
      end
      default: begin
        state_n  = IDLE;
        cd_val_n = 4'd0;
      end
    endcase

    if (state_n == GAME_OVER && state != GAME_OVER) begin
      hold_cnt_n = 4'd0;
    end
  end

  assign enter_countdown = (state_n == COUNTDOWN) && (state != COUNTDOWN);
  assign enter_game_over = (state_n == GAME_OVER) && (state != GAME_OVER);
  assign sec_clear       = enter_countdown | enter_game_over;

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cd_val     <= 4'd0;
      hold_cnt   <= 4'd0;
      go_q       <= 1'b0;
      restart_q  <= 1'b1;
      input_en_q <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cd_val     <= cd_val_n;
      hold_cnt   <= hold_cnt_n;
      go_q       <= (state_n == PLAYING);
      restart_q  <= (state_n == IDLE) || enter_countdown;
      input_en_q <= (state_n == PLAYING);
      over_q     <= enter_game_over;
    end
  end

  assign bus.game_state    = state;
  assign bus.countdown_val = cd_val;
  assign bus.timer_go      = go_q;
  assign bus.timer_restart = restart_q;
  assign bus.input_enable  = input_en_q;
  assign bus.game_over     = over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Table-driven bench for game_round_ctrl with a scoreboard queue and a behavioural round timer.
module tb_game_round_ctrl;
  import game_pkg::*;

  localparam logic [3:0]  CD_SECS    = 4'd3;
  localparam logic [23:0] ONE_SEC    = 24'd4;
  localparam logic [3:0]  HOLD_SECS  = 4'd2;
  localparam logic [7:0]  GIVEN_TIME = 8'd200;

  typedef struct {
    logic       rst;
    logic       st;
    logic       ps;
    logic       tz;
    int         reps;
    logic [2:0] state_e;
    logic [3:0] cv_e;
    logic       go_e;
    logic       rs_e;
    logic       ie_e;
    logic       ov_e;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic force_zero = 1'b0;
  logic [7:0] model_tl = GIVEN_TIME;
  logic [23:0] model_sub = '0;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  game_round_ctrl_if bus ();

  game_round_ctrl #(
    .COUNTDOWN_SECS (CD_SECS),
    .ONE_SEC        (ONE_SEC),
    .OVER_HOLD_SECS (HOLD_SECS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural round timer: reloads on restart, counts down one per second while enabled.
  always @(posedge clock) begin
    if (bus.timer_restart) begin
      model_tl  <= GIVEN_TIME;
      model_sub <= '0;
    end else if (bus.timer_go) begin
      if (model_sub == ONE_SEC - 24'd1) begin
        model_sub <= '0;
        if (model_tl != 8'd0) model_tl <= model_tl - 8'd1;
      end else begin
        model_sub <= model_sub + 24'd1;
      end
    end
  end

  assign bus.time_left = force_zero ? 8'd0 : model_tl;

  function automatic vec_t mkv(input logic rst, st, ps, tz, input int reps,
                               input logic [2:0] s, input logic [3:0] cv,
                               input logic go, rs, ie, ov);
    vec_t v;
    v.rst = rst; v.st = st; v.ps = ps; v.tz = tz; v.reps = reps;
    v.state_e = s; v.cv_e = cv; v.go_e = go; v.rs_e = rs; v.ie_e = ie; v.ov_e = ov;
    return v;
  endfunction

  task automatic checkField(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_q.push_back(v);
    for (int r = 0; r < v.reps; r++) begin
      @(negedge clock);
      reset         = v.rst;
      bus.start_btn = v.st;
      bus.pause_btn = v.ps;
      force_zero    = v.tz;
      @(posedge clock);
    end
    #1;
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL v%0d scoreboard empty", idx);
    end else begin
      e = exp_q.pop_front();
      checkField($sformatf("v%0d game_state", idx), int'(bus.game_state), int'(e.state_e));
      checkField($sformatf("v%0d countdown_val", idx), int'(bus.countdown_val), int'(e.cv_e));
      checkField($sformatf("v%0d timer_go", idx), int'(bus.timer_go), int'(e.go_e));
      checkField($sformatf("v%0d timer_restart", idx), int'(bus.timer_restart), int'(e.rs_e));
      checkField($sformatf("v%0d input_enable", idx), int'(bus.input_enable), int'(e.ie_e));
      checkField($sformatf("v%0d game_over", idx), int'(bus.game_over), int'(e.ov_e));
    end
  endtask

  initial begin
    int dwell;
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;

    //                rst st ps tz reps state      cv go rs ie ov
    vecs.push_back(mkv(1, 0, 0, 0, 2,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 3,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  COUNTDOWN, 3, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  COUNTDOWN, 3, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 2,  COUNTDOWN, 3, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  COUNTDOWN, 2, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 3,  COUNTDOWN, 2, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  COUNTDOWN, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 3,  COUNTDOWN, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1,  PAUSED,    0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  PAUSED,    0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1,  PAUSED,    0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  PAUSED,    0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 1, 0, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1,  PAUSED,    0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  PAUSED,    0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  COUNTDOWN, 3, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 11, COUNTDOWN, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 1,  GAME_OVER, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  GAME_OVER, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  GAME_OVER, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 4,  GAME_OVER, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  GAME_OVER, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  GAME_OVER, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  COUNTDOWN, 3, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  COUNTDOWN, 3, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 1,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 1,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  IDLE,      0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1,  COUNTDOWN, 3, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 11, COUNTDOWN, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 1,  PLAYING,   0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 1,  GAME_OVER, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 1,  GAME_OVER, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Let the game-over hold expire, restart, and measure the countdown dwell cycle by cycle.
    repeat (10) @(posedge clock);
    @(negedge clock);
    bus.start_btn = 1'b1;
    @(posedge clock);
    #1;
    checkField("rerun enters countdown", int'(bus.game_state), int'(COUNTDOWN));
    checkField("rerun restart pulse", int'(bus.timer_restart), 1);
    @(negedge clock);
    bus.start_btn = 1'b0;
    dwell = 1;
    @(posedge clock);
    #1;
    while (bus.game_state != PLAYING && dwell < 40) begin
      @(posedge clock);
      #1;
      dwell++;
    end
    checkField("countdown dwell cycles", dwell, int'(CD_SECS) * int'(ONE_SEC));
    checkField("dwell ends with timer_go", int'(bus.timer_go), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
